// File: rtl/mulpop_bus_driver.sv
// mulpop_bus_driver: bus-master sequencer for the multiply/popcount peripheral.
// Takes an A1/A2 operand pair, writes A1, A2 and start, polls status, then
// reads back W and L and presents them on an output valid/ready stream.
// Every bus access takes three clocks: SETUP, STROBE, HOLD.
// Optional feature macro: CHECK_POP_EN. When defined, a local popcount of the
// returned W is compared with the returned L, and out_lerr flags a mismatch.
module mulpop_bus_driver #(
  parameter logic [15:0] ADDR_A1    = 16'h037F,
  parameter logic [15:0] ADDR_A2    = 16'h0388,
  parameter logic [15:0] ADDR_CTRL  = 16'h03A0,
  parameter logic [15:0] ADDR_W     = 16'h0390,
  parameter logic [15:0] ADDR_L     = 16'h0398,
  parameter int          START_WAIT = 4,
  parameter int          POLL_LIMIT = 255
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_a1,
  input  logic [23:0] in_a2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_w,
  output logic [5:0]  out_l,
  output logic        out_ovf,
  output logic        out_tmo,
  output logic        out_lerr,
  output logic [15:0] saddress,
  output logic        swr,
  output logic        srd,
  output logic [31:0] sdata_wr,
  input  logic [31:0] sdata_rd
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_A1, S_WR_A2, S_WR_GO, S_WAIT, S_POLL, S_RD_W, S_RD_L, S_OUT
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

  // WAIT counts down from START_WAIT-1 to 0, giving START_WAIT idle clocks.
  localparam logic [7:0] WAIT_LOAD = 8'(START_WAIT - 1);
  localparam logic [7:0] POLL_LIM8 = 8'(POLL_LIMIT);

  state_t      r_state;
  phase_t      r_phase;
  logic [23:0] r_a2;
  logic [7:0]  r_wait;
  logic [7:0]  r_polls;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [31:0] r_w;
  logic [5:0]  r_l;
  logic        r_ovf;
  logic        r_tmo;
  logic [15:0] r_saddress;
  logic        r_swr;
  logic        r_srd;
  logic [31:0] r_sdata_wr;

  logic        w_is_write;
  logic [7:0]  w_polls_inc;

`ifdef CHECK_POP_EN
  logic        r_lerr;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction
`endif

  // The three register writes use swr; every other access state reads.
  assign w_is_write  = (r_state == S_WR_A1) || (r_state == S_WR_A2) || (r_state == S_WR_GO);
  // Poll counter saturates instead of wrapping.
  assign w_polls_inc = (r_polls == 8'hFF) ? r_polls : r_polls + 8'd1;

  // Sequencer: state, bus phase and all registered outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= S_IDLE;
      r_phase     <= PH_SETUP;
      r_a2        <= '0;
      r_wait      <= '0;
      r_polls     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_w         <= '0;
      r_l         <= '0;
      r_ovf       <= 1'b0;
      r_tmo       <= 1'b0;
      r_saddress  <= '0;
      r_swr       <= 1'b0;
      r_srd       <= 1'b0;
      r_sdata_wr  <= '0;
`ifdef CHECK_POP_EN
      r_lerr      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a2       <= in_a2;
            r_polls    <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_WR_A1;
            r_phase    <= PH_SETUP;
            r_saddress <= ADDR_A1;
            r_sdata_wr <= {8'h00, in_a1};
          end
        end

        S_WAIT: begin
          if (r_wait == 8'd0) begin
            r_state    <= S_POLL;
            r_phase    <= PH_SETUP;
            r_saddress <= ADDR_CTRL;
          end else begin
            r_wait <= r_wait - 8'd1;
          end
        end

        S_OUT: begin
          // Result stays stable until the consumer takes it.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_w         <= '0;
            r_l         <= '0;
            r_ovf       <= 1'b0;
            r_tmo       <= 1'b0;
`ifdef CHECK_POP_EN
            r_lerr      <= 1'b0;
`endif
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          // Bus access states share the SETUP/STROBE/HOLD sequencing.
          case (r_phase)
            PH_SETUP: begin
              r_phase <= PH_STROBE;
              r_swr   <= w_is_write;
              r_srd   <= ~w_is_write;
            end
            PH_STROBE: begin
              r_phase <= PH_HOLD;
              r_swr   <= 1'b0;
              r_srd   <= 1'b0;
            end
            default: begin
              // End of HOLD: read data is sampled here and the next access is set up.
              r_phase <= PH_SETUP;
              case (r_state)
                S_WR_A1: begin
                  r_state    <= S_WR_A2;
                  r_saddress <= ADDR_A2;
                  r_sdata_wr <= {8'h00, r_a2};
                end
                S_WR_A2: begin
                  r_state    <= S_WR_GO;
                  r_saddress <= ADDR_CTRL;
                  r_sdata_wr <= 32'h0;
                end
                S_WR_GO: begin
                  r_state    <= S_WAIT;
                  r_saddress <= '0;
                  r_sdata_wr <= 32'h0;
                  r_wait     <= WAIT_LOAD;
                end
                S_POLL: begin
                  r_polls <= w_polls_inc;
                  if (sdata_rd[1]) begin
                    r_ovf      <= ~sdata_rd[0];
                    r_state    <= S_RD_W;
                    r_saddress <= ADDR_W;
                  end else if (w_polls_inc < POLL_LIM8) begin
                    r_state    <= S_WAIT;
                    r_saddress <= '0;
                    r_wait     <= WAIT_LOAD;
                  end else begin
                    // Gave up: report timeout with zeroed results, no W/L reads.
                    r_tmo       <= 1'b1;
                    r_w         <= '0;
                    r_l         <= '0;
                    r_state     <= S_OUT;
                    r_out_valid <= 1'b1;
                    r_saddress  <= '0;
                  end
                end
                S_RD_W: begin
                  r_w        <= sdata_rd;
                  r_state    <= S_RD_L;
                  r_saddress <= ADDR_L;
                end
                S_RD_L: begin
                  r_l         <= sdata_rd[5:0];
`ifdef CHECK_POP_EN
                  r_lerr      <= (popcount32(r_w) != sdata_rd[5:0]);
`endif
                  r_state     <= S_OUT;
                  r_out_valid <= 1'b1;
                  r_saddress  <= '0;
                end
                default: begin
                  r_state    <= S_IDLE;
                  r_saddress <= '0;
                end
              endcase
            end
          endcase
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_w     = r_w;
  assign out_l     = r_l;
  assign out_ovf   = r_ovf;
  assign out_tmo   = r_tmo;
  assign saddress  = r_saddress;
  assign swr       = r_swr;
  assign srd       = r_srd;
  assign sdata_wr  = r_sdata_wr;
`ifdef CHECK_POP_EN
  assign out_lerr  = r_lerr;
`else
  assign out_lerr  = 1'b0;
`endif

endmodule

// File: tb/tb_mulpop_bus_driver.sv
// tb_mulpop_bus_driver: scoreboard bench for mulpop_bus_driver with a
// behavioural slave model of the multiply/popcount peripheral.
module tb_mulpop_bus_driver;

  localparam logic [15:0] A_A1   = 16'h037F;
  localparam logic [15:0] A_A2   = 16'h0388;
  localparam logic [15:0] A_CTRL = 16'h03A0;
  localparam logic [15:0] A_W    = 16'h0390;
  localparam logic [15:0] A_L    = 16'h0398;
  localparam int          POLLS  = 255;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_a1 = '0;
  logic [23:0] in_a2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_w;
  logic [5:0]  out_l;
  logic        out_ovf, out_tmo, out_lerr;
  logic [15:0] saddress;
  logic        swr, srd;
  logic [31:0] sdata_wr;
  logic [31:0] sdata_rd;

  mulpop_bus_driver dut (
    .clk(clk), .n_reset(n_reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a1(in_a1), .in_a2(in_a2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_w(out_w), .out_l(out_l), .out_ovf(out_ovf), .out_tmo(out_tmo), .out_lerr(out_lerr),
    .saddress(saddress), .swr(swr), .srd(srd), .sdata_wr(sdata_wr), .sdata_rd(sdata_rd)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] pop32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

  // ---------------- slave model ----------------
  logic [23:0] sl_a1 = '0;
  logic [23:0] sl_a2 = '0;
  int          sl_ready_at = 1;     // poll number that first reports ready; 0 = never
  int          sl_poll_cnt = 0;
  int          wl_reads = 0;
  bit          sl_l_ovr_en = 1'b0;
  logic [5:0]  sl_l_ovr = '0;
  logic [63:0] sl_prod;
  logic        sl_ready;

  assign sl_prod  = {40'h0, sl_a1} * {40'h0, sl_a2};
  assign sl_ready = (sl_ready_at != 0) && (sl_poll_cnt >= sl_ready_at);

  always_comb begin
    sdata_rd = 32'h0;
    case (saddress)
      A_CTRL:  sdata_rd = {30'h0, sl_ready, (sl_prod[63:32] == 32'h0)};
      A_W:     sdata_rd = sl_prod[31:0];
      A_L:     sdata_rd = {26'h2AAAAAA, (sl_l_ovr_en ? sl_l_ovr : pop32(sl_prod[31:0]))};
      default: sdata_rd = 32'h0;
    endcase
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] w;
    logic [5:0]  l;
    logic        ovf;
    logic        tmo;
    logic        lerr;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [47:0] wr_log[$];
  int          cyc = 0;
  int          acc_cyc = 0;
  int          last_hand = -1;
  bit          b2b_mode = 1'b0;
  bit          prev_ov = 1'b0;
  bit          both_seen = 1'b0;

  function automatic exp_t model(input logic [23:0] a1, input logic [23:0] a2);
    exp_t        e;
    logic [63:0] p;
    logic [5:0]  lret;
    p = {40'h0, a1} * {40'h0, a2};
    lret = sl_l_ovr_en ? sl_l_ovr : pop32(p[31:0]);
    if (sl_ready_at == 0) begin
      e.w = '0; e.l = '0; e.ovf = 1'b0; e.tmo = 1'b1; e.lerr = 1'b0;
      e.lat = 9 + 7 * POLLS;
    end else begin
      e.w = p[31:0]; e.l = lret; e.ovf = (p[63:32] != 32'h0); e.tmo = 1'b0;
`ifdef CHECK_POP_EN
      e.lerr = (lret != pop32(p[31:0]));
`else
      e.lerr = 1'b0;
`endif
      e.lat = 22 + 7 * (sl_ready_at - 1);
    end
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: bus log, slave bookkeeping, scoreboard push/pop; samples on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!n_reset) begin
      sb_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (swr && srd) both_seen = 1'b1;
      if (swr) begin
        wr_log.push_back({saddress, sdata_wr});
        case (saddress)
          A_A1:    sl_a1 = sdata_wr[23:0];
          A_A2:    sl_a2 = sdata_wr[23:0];
          A_CTRL:  begin sl_poll_cnt = 0; wl_reads = 0; end
          default: ;
        endcase
      end
      if (srd) begin
        if (saddress == A_CTRL) sl_poll_cnt++;
        else if (saddress == A_W || saddress == A_L) wl_reads++;
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(in_a1, in_a2));
        acc_cyc = cyc + 1;
        if (b2b_mode && last_hand >= 0) check_val("b2b_gap", 64'(acc_cyc - last_hand), 64'd1);
      end
      if (out_valid && !prev_ov && sb_q.size() > 0)
        check_val("latency", 64'(cyc - acc_cyc), 64'(sb_q[0].lat));
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check_val("out_w", 64'(out_w), 64'(e.w));
          check_val("out_l", 64'(out_l), 64'(e.l));
          check_val("out_ovf", 64'(out_ovf), 64'(e.ovf));
          check_val("out_tmo", 64'(out_tmo), 64'(e.tmo));
          check_val("out_lerr", 64'(out_lerr), 64'(e.lerr));
          $display("result w=%08h l=%0d ovf=%0d tmo=%0d lerr=%0d", out_w, out_l, out_ovf, out_tmo, out_lerr);
        end
        last_hand = cyc + 1;
      end
      if (!b2b_mode) last_hand = -1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check_val("in_ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input logic [23:0] a1, input logic [23:0] a2);
    @(posedge clk); #1;
    in_a1 = a1; in_a2 = a2; in_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && in_ready && !out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check_val("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int base;
    bit ok;

    // Reset values, sampled while reset is held.
    repeat (2) @(negedge clk);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_strobes", 64'({swr, srd}), 64'd0);
    check_val("rst_saddress", 64'(saddress), 64'd0);
    check_val("rst_sdata_wr", 64'(sdata_wr), 64'd0);
    check_val("rst_results", 64'({out_w, out_l, out_ovf, out_tmo, out_lerr}), 64'd0);
    @(posedge clk); #2 n_reset = 1'b1;

    // 3 * 5, ready on first poll: register writes, result, 22-clock latency.
    sl_ready_at = 1;
    base = wr_log.size();
    send(24'd3, 24'd5);
    wait_done();
    check_val("wr_count", 64'(wr_log.size() - base), 64'd3);
    if (wr_log.size() - base == 3) begin
      check_val("wr_a1", 64'(wr_log[base]), 64'({A_A1, 32'd3}));
      check_val("wr_a2", 64'(wr_log[base + 1]), 64'({A_A2, 32'd5}));
      check_val("wr_go", 64'(wr_log[base + 2]), 64'({A_CTRL, 32'd0}));
    end
    check_val("polls_first", 64'(sl_poll_cnt), 64'd1);
    check_val("wl_reads", 64'(wl_reads), 64'd2);
    check_val("idle_saddress", 64'(saddress), 64'd0);

    // Overflowing product.
    send(24'hFFFFFF, 24'hFFFFFF);
    wait_done();

    // Ready only on the third poll.
    sl_ready_at = 3;
    send(24'h123456, 24'h00ABCD);
    wait_done();
    check_val("polls_third", 64'(sl_poll_cnt), 64'd3);

    // Never ready: timeout after the poll limit, no W/L reads.
    sl_ready_at = 0;
    base = wr_log.size();
    send(24'h0A0B0C, 24'h000102);
    wait_done();
    check_val("tmo_polls", 64'(sl_poll_cnt), 64'(POLLS));
    check_val("tmo_wl_reads", 64'(wl_reads), 64'd0);
    check_val("tmo_wr_count", 64'(wr_log.size() - base), 64'd3);
    sl_ready_at = 1;

    // Consumer stalls for 10 clocks: result held, no new acceptance.
    @(posedge clk); #1 out_ready = 1'b0;
    send(24'h00F0F0, 24'h000077);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check_val("stall_out_valid_timeout", 64'd0, 64'd1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check_val("stall_valid", 64'(out_valid), 64'd1);
      check_val("stall_in_ready", 64'(in_ready), 64'd0);
      if (sb_q.size() > 0) check_val("stall_w", 64'(out_w), 64'(sb_q[0].w));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check_val("stall_in_ready_pre", 64'(in_ready), 64'd0);
    @(negedge clk);
    check_val("stall_in_ready_post", 64'(in_ready), 64'd1);
    check_val("stall_valid_post", 64'(out_valid), 64'd0);

    // Reset asserted during the A2 write strobe.
    send(24'h000011, 24'h000022);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (swr && saddress == A_A2) begin ok = 1'b1; break; end
    end
    if (!ok) check_val("a2_strobe_timeout", 64'd0, 64'd1);
    #1 n_reset = 1'b0;
    #1;
    check_val("arst_swr", 64'(swr), 64'd0);
    check_val("arst_in_ready", 64'(in_ready), 64'd1);
    check_val("arst_saddress", 64'(saddress), 64'd0);
    @(negedge clk);
    @(posedge clk); #2 n_reset = 1'b1;
    @(negedge clk);
    check_val("post_rst_in_ready", 64'(in_ready), 64'd1);
    check_val("post_rst_valid", 64'(out_valid), 64'd0);

    // Normal operation after the reset.
    send(24'h000007, 24'h000009);
    wait_done();

    // Slave returns a wrong L, then the right one.
    sl_l_ovr_en = 1'b1;
    sl_l_ovr = 6'd5;
    send(24'd3, 24'd5);
    wait_done();
    sl_l_ovr = 6'd4;
    send(24'd3, 24'd5);
    wait_done();
    sl_l_ovr_en = 1'b0;

    // Back-to-back pairs with in_valid held high.
    @(posedge clk); #1 b2b_mode = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_a1 = 24'($urandom());
      in_a2 = 24'($urandom());
      wait_ready();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_done();
    b2b_mode = 1'b0;

    check_val("both_strobes", 64'(both_seen), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Absolute time bound on the whole run.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "global timeout");
  end

endmodule
